// File: rtl/btn_ctrl.sv
// btn_ctrl: synchronizes, debounces, edge-detects and arbitrates three push-buttons
// into one-cycle MODE/SELECT/ADJUST pulses, and generates the sig2hz blink. Optional macro: BTN_AUTOREPEAT_EN.
module btn_ctrl #(
    parameter int SAMPLE_DIV = 50000,
    parameter int DEB_TICKS  = 4,
    parameter int BLINK_DIV  = 12500000,
    parameter int RPT_DELAY  = 500,
    parameter int RPT_RATE   = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_mode,
    input  logic btn_select,
    input  logic btn_adjust,
    output logic MODE,
    output logic SELECT,
    output logic ADJUST,
    output logic sig2hz
);

    localparam int TW = $clog2(SAMPLE_DIV) + 1;
    localparam int DW = $clog2(DEB_TICKS) + 1;
    localparam int BW = $clog2(BLINK_DIV) + 1;

    if (SAMPLE_DIV < 2 || DEB_TICKS < 1 || BLINK_DIV < 1 || RPT_DELAY < 1 || RPT_RATE < 1) begin : g_bad_params
        $error("btn_ctrl: parameter out of range");
    end

    // Bit order everywhere: [0] mode, [1] select, [2] adjust.
    logic [2:0] raw;
    logic [2:0] s1;
    logic [2:0] s2;

    assign raw = {btn_adjust, btn_select, btn_mode};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    logic [TW-1:0] tcnt;
    logic          tick;

    assign tick = (tcnt == TW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // A level flips only after DEB_TICKS consecutive disagreeing samples.
    logic [2:0]    db;
    logic [DW-1:0] dc [3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db <= '0;
            for (int i = 0; i < 3; i++) begin
                dc[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == db[i]) begin
                    dc[i] <= '0;
                end else if (dc[i] == DW'(DEB_TICKS - 1)) begin
                    db[i] <= ~db[i];
                    dc[i] <= '0;
                end else begin
                    dc[i] <= dc[i] + 1'b1;
                end
            end
        end
    end

    logic [2:0] db_prev;
    logic [2:0] rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_prev <= '0;
        end else begin
            db_prev <= db;
        end
    end

    assign rise = db & ~db_prev;

    logic adj_req;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int RW      = $clog2(RPT_MAX) + 1;

    logic [RW-1:0] rcnt;
    logic [RW-1:0] rpt_limit;
    logic          rpt_phase;
    logic          rep_req;

    assign rpt_limit = rpt_phase ? RW'(RPT_RATE - 1) : RW'(RPT_DELAY - 1);

    // Counts only ticks where the button still reads held, so the release
    // debounce window never produces a trailing repeat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt      <= '0;
            rpt_phase <= 1'b0;
            rep_req   <= 1'b0;
        end else if (!db[2] || rise[2]) begin
            rcnt      <= '0;
            rpt_phase <= 1'b0;
            rep_req   <= 1'b0;
        end else if (tick && s2[2]) begin
            if (rcnt == rpt_limit) begin
                rcnt      <= '0;
                rpt_phase <= 1'b1;
                rep_req   <= 1'b1;
            end else begin
                rcnt    <= rcnt + 1'b1;
                rep_req <= 1'b0;
            end
        end else begin
            rep_req <= 1'b0;
        end
    end

    assign adj_req = rise[2] | rep_req;
`else
    assign adj_req = rise[2];
`endif

    // Fixed priority MODE > SELECT > ADJUST; losing requests are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MODE   <= 1'b0;
            SELECT <= 1'b0;
            ADJUST <= 1'b0;
        end else begin
            MODE   <= rise[0];
            SELECT <= rise[1] & ~rise[0];
            ADJUST <= adj_req & ~rise[1] & ~rise[0];
        end
    end

    logic [BW-1:0] bcnt;
    logic          bwrap;

    assign bwrap = (bcnt == BW'(BLINK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt   <= '0;
            sig2hz <= 1'b0;
        end else begin
            bcnt   <= bwrap ? '0 : bcnt + 1'b1;
            sig2hz <= sig2hz ^ bwrap;
        end
    end

endmodule

// File: tb/tb_btn_ctrl.sv
// Self-checking bench for btn_ctrl: cycle scoreboard against a tick-window reference
// model, a vector table of press patterns, and hand sequences for multi-cycle corners.
module tb_btn_ctrl;

    localparam int SD = 4;
    localparam int DT = 3;
    localparam int BD = 10;
    localparam int RD = 8;
    localparam int RR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_mode = 1'b0;
    logic btn_select = 1'b0;
    logic btn_adjust = 1'b0;
    logic MODE, SELECT, ADJUST, sig2hz;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    btn_ctrl #(
        .SAMPLE_DIV(SD),
        .DEB_TICKS (DT),
        .BLINK_DIV (BD),
        .RPT_DELAY (RD),
        .RPT_RATE  (RR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_select(btn_select),
        .btn_adjust(btn_adjust),
        .MODE      (MODE),
        .SELECT    (SELECT),
        .ADJUST    (ADJUST),
        .sig2hz    (sig2hz)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edges numbered from reset release, ticks at every SD-th edge,
    // a level flips once its last DT tick samples all disagree with it.
    int         e_m;
    int         k_m;
    bit [2:0]   inq[$];
    bit         win[3][$];
    bit [2:0]   db_m, db_old_m, pend_rise, s_m, cur_m;
    bit         pend_rep, rep_m, tick_m, all_diff;
    logic [3:0] exp_m;
    logic [3:0] exp_q[$];

    function automatic logic [3:0] arb(input bit [2:0] r, input bit rep);
        if (r[0]) return 4'b1000;
        if (r[1]) return 4'b0100;
        if (r[2] || rep) return 4'b0010;
        return 4'b0000;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_m = 0;
            k_m = 0;
            inq.delete();
            for (int b = 0; b < 3; b++) win[b].delete();
            db_m = '0;
            pend_rise = '0;
            pend_rep = 1'b0;
            exp_q.delete();
        end else begin
            e_m++;
            cur_m = {btn_adjust, btn_select, btn_mode};
            s_m = (inq.size() >= 2) ? inq[inq.size()-2] : 3'b000;
            inq.push_back(cur_m);
            if (inq.size() > 2) void'(inq.pop_front());

            exp_m = arb(pend_rise, pend_rep);
            exp_m[0] = ((e_m / BD) % 2) == 1;
            exp_q.push_back(exp_m);

            tick_m = (e_m % SD) == 0;
            db_old_m = db_m;
            rep_m = 1'b0;
            if (tick_m) begin
                for (int b = 0; b < 3; b++) begin
                    win[b].push_back(s_m[b]);
                    if (win[b].size() > DT) void'(win[b].pop_front());
                    all_diff = (win[b].size() == DT);
                    for (int j = 0; j < win[b].size(); j++)
                        if (win[b][j] == db_m[b]) all_diff = 1'b0;
                    if (all_diff) db_m[b] = ~db_m[b];
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            if (tick_m && db_old_m[2] && s_m[2]) begin
                k_m++;
                rep_m = (k_m == RD) || (k_m > RD && ((k_m - RD) % RR) == 0);
            end
`endif
            if (!db_m[2]) k_m = 0;
            pend_rise = db_m & ~db_old_m;
            pend_rep = rep_m;
        end
    end

    // Scoreboard and pulse counters, sampled away from the active edge.
    logic [3:0] exp_chk;
    int n_mode = 0, n_sel = 0, n_adj = 0;

    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs", {28'd0, MODE, SELECT, ADJUST, sig2hz}, 32'd0);
        end else begin
            if (exp_q.size() > 0) begin
                exp_chk = exp_q.pop_front();
                check("cycle_model", {28'd0, MODE, SELECT, ADJUST, sig2hz}, {28'd0, exp_chk});
            end
            n_mode += int'(MODE);
            n_sel += int'(SELECT);
            n_adj += int'(ADJUST);
        end
    end

    task automatic drive(input logic [2:0] b);
        btn_mode = b[0];
        btn_select = b[1];
        btn_adjust = b[2];
    endtask

    task automatic wait_pulse(input int which, input int limit, output int lat, output bit found);
        found = 1'b0;
        lat = 0;
        while (lat < limit && !found) begin
            @(negedge clk);
            lat++;
            case (which)
                0: found = MODE;
                1: found = SELECT;
                default: found = ADJUST;
            endcase
        end
    endtask

    typedef struct {
        logic [2:0] btns;
        int         hold;
        int         n_mode;
        int         n_sel;
        int         n_adj;
    } vec_t;

    vec_t vecs[8];
    int   m0, s0, a0, lat, tog, exp_adj;
    bit   found;
    logic prev_sig;

    initial begin
        vecs[0] = '{3'b001, 40, 1, 0, 0};
        vecs[1] = '{3'b010, 24, 0, 1, 0};
        vecs[2] = '{3'b100, 24, 0, 0, 1};
        vecs[3] = '{3'b101, 24, 1, 0, 0};
        vecs[4] = '{3'b110, 24, 0, 1, 0};
        vecs[5] = '{3'b011, 24, 1, 0, 0};
        vecs[6] = '{3'b111, 24, 1, 0, 0};
        vecs[7] = '{3'b000, 24, 0, 0, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: blink toggles every BD cycles, no commands.
        prev_sig = 1'b0;
        tog = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sig2hz !== prev_sig) tog++;
            prev_sig = sig2hz;
        end
        check("blink_toggles_100", tog, 10);
        check("idle_no_commands", n_mode + n_sel + n_adj, 0);

        // Clean MODE press: latency bound and a single pulse.
        m0 = n_mode;
        drive(3'b001);
        wait_pulse(0, 16, lat, found);
        check("mode_press_within_16", found, 1);
        repeat (40 - lat) @(negedge clk);
        drive(3'b000);
        repeat (40) @(negedge clk);
        check("mode_single_pulse", n_mode - m0, 1);

        // SELECT glitching, then settled.
        s0 = n_sel;
        for (int i = 0; i < 20; i++) begin
            btn_select = (i % 2 == 0);
            repeat (3) @(negedge clk);
        end
        check("glitch_no_select", n_sel - s0, 0);
        btn_select = 1'b1;
        wait_pulse(1, 16, lat, found);
        check("select_after_settle_16", found, 1);
        repeat (20) @(negedge clk);
        drive(3'b000);
        repeat (40) @(negedge clk);
        check("select_single_pulse", n_sel - s0, 1);

        for (int v = 0; v < 8; v++) begin
            m0 = n_mode; s0 = n_sel; a0 = n_adj;
            drive(vecs[v].btns);
            repeat (vecs[v].hold) @(negedge clk);
            drive(3'b000);
            repeat (40) @(negedge clk);
            check($sformatf("vec%0d_mode", v), n_mode - m0, vecs[v].n_mode);
            check($sformatf("vec%0d_select", v), n_sel - s0, vecs[v].n_sel);
            check($sformatf("vec%0d_adjust", v), n_adj - a0, vecs[v].n_adj);
        end

        // ADJUST held 30 ticks: 27 held ticks after debounce -> repeats at 8,12,16,20,24.
`ifdef BTN_AUTOREPEAT_EN
        exp_adj = 6;
`else
        exp_adj = 1;
`endif
        a0 = n_adj;
        drive(3'b100);
        repeat (120) @(negedge clk);
        drive(3'b000);
        repeat (40) @(negedge clk);
        check("adjust_hold_120", n_adj - a0, exp_adj);

        // Reset in mid-debounce, button held through reset release.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        m0 = n_mode;
        drive(3'b001);
        repeat (9) @(negedge clk);
        check("sig_high_before_reset", sig2hz, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_clears", {28'd0, MODE, SELECT, ADJUST, sig2hz}, 32'd0);
        check("no_mode_mid_debounce", n_mode - m0, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_pulse(0, 30, lat, found);
        check("mode_after_reset_found", found, 1);
        check("mode_after_reset_latency", lat, 13);
        repeat (10) @(negedge clk);
        drive(3'b000);
        repeat (40) @(negedge clk);
        check("mode_after_reset_single", n_mode - m0, 1);

        // Randomized presses against the model.
        for (int i = 0; i < 40; i++) begin
            drive(3'($urandom_range(0, 7)));
            repeat ($urandom_range(1, 60)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) drive(3'b000);
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        drive(3'b000);
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
